// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched -- programmable clock-enable scheduler
//
// Emits a one-cycle enable pulse (clk_flag) once every N sys_clk cycles while
// a run is active. A run emits either a fixed number of ticks (burst_len) or
// runs continuously (burst_len == 0) until stop. Periods are never truncated.
// The divide ratio can be changed at any time through a valid/ready
// handshake. While running, a new ratio is parked in a shadow register and
// takes effect only at the next period wrap.
//
// Parameters
//   CNT_W      width of the period counter and ratio (3..16)
//   BL_W       width of the burst-length counter
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   cfg_valid  in   ratio update request
//   cfg_ratio  in   requested divide ratio N (legal: N >= 2)
//   cfg_ready  out  ratio update can be accepted
//   cfg_err    out  one-cycle pulse: accepted ratio was illegal, discarded
//   start      in   begin a run (sampled in IDLE only)
//   burst_len  in   ticks to emit in the run, 0 = continuous
//   stop       in   end the run at the next period boundary
//   clk_flag   out  one-cycle enable pulse, once per N cycles
//   busy       out  high while a run is active
//   done       out  one-cycle pulse after a run ends
//   clk_out    out  square wave, high for cnt < N/2 (only with the macro)
//
// Build option
//   DIV_SCHED_SQ_EN  when defined, adds the registered clk_out output.
//
// All outputs are registered. Each one is computed from the next-state
// values so that it lines up with the counter value it describes.
// ---------------------------------------------------------------------------
module div_sched #(
  parameter int CNT_W = 8,
  parameter int BL_W  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             start,
  input  logic [BL_W-1:0]  burst_len,
  input  logic             stop,
  output logic             clk_flag,
  output logic             busy,
  output logic             done
`ifdef DIV_SCHED_SQ_EN
  ,
  output logic             clk_out
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(6);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] act_ratio, ratio_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt;
  logic             shadow_vld, shadow_vld_nxt;
  logic             stop_pend, stop_pend_nxt;
  logic [BL_W-1:0]  remain, remain_nxt;
  logic             cont, cont_nxt;
  logic             cfg_hs, cfg_legal, at_wrap, run_end;
  logic             flag_nxt, done_nxt, err_nxt, ready_nxt;
`ifdef DIV_SCHED_SQ_EN
  logic             sq_nxt;
`endif

  // Next-state and next-output logic for the whole block.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ratio_nxt      = act_ratio;
    shadow_nxt     = shadow;
    shadow_vld_nxt = shadow_vld;
    stop_pend_nxt  = stop_pend;
    remain_nxt     = remain;
    cont_nxt       = cont;
    ready_nxt      = cfg_ready;

    cfg_hs    = cfg_valid && cfg_ready;
    cfg_legal = (cfg_ratio >= TWO);
    at_wrap   = (state == RUN) && (cnt == act_ratio - ONE);
    // A stop arriving in the boundary cycle itself ends the run at that
    // boundary. The period has completed, so nothing is truncated.
    run_end   = at_wrap && (stop_pend || stop || (!cont && remain == BL_ONE));
    err_nxt   = cfg_hs && !cfg_legal;

    case (state)
      IDLE: begin
        cnt_nxt       = '0;
        stop_pend_nxt = 1'b0;
        if (cfg_hs && cfg_legal) begin
          ratio_nxt = cfg_ratio;
        end
        if (start) begin
          state_nxt  = RUN;
          remain_nxt = burst_len;
          cont_nxt   = (burst_len == '0);
        end
      end
      RUN: begin
        if (stop) begin
          stop_pend_nxt = 1'b1;
        end
        if (at_wrap) begin
          cnt_nxt = '0;
          if (!cont) begin
            remain_nxt = remain - BL_ONE;
          end
          if (shadow_vld) begin
            ratio_nxt      = shadow;
            shadow_vld_nxt = 1'b0;
            ready_nxt      = 1'b1;
          end
          // A handshake that lands exactly on the wrap edge has nothing left
          // to wait for, so it is applied directly instead of being parked.
          if (cfg_hs && cfg_legal) begin
            ratio_nxt = cfg_ratio;
          end
          if (run_end) begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + ONE;
          if (cfg_hs && cfg_legal) begin
            shadow_nxt     = cfg_ratio;
            shadow_vld_nxt = 1'b1;
            ready_nxt      = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    flag_nxt = (state_nxt == RUN) && (cnt_nxt == ratio_nxt - ONE);
    done_nxt = (state == RUN) && (state_nxt == IDLE);
`ifdef DIV_SCHED_SQ_EN
    sq_nxt   = (state_nxt == RUN) && (cnt_nxt < (ratio_nxt >> 1));
`endif
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      act_ratio  <= RST_RATIO;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      stop_pend  <= 1'b0;
      remain     <= '0;
      cont       <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      clk_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DIV_SCHED_SQ_EN
      clk_out    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      act_ratio  <= ratio_nxt;
      shadow     <= shadow_nxt;
      shadow_vld <= shadow_vld_nxt;
      stop_pend  <= stop_pend_nxt;
      remain     <= remain_nxt;
      cont       <= cont_nxt;
      cfg_ready  <= ready_nxt;
      cfg_err    <= err_nxt;
      clk_flag   <= flag_nxt;
      busy       <= (state_nxt == RUN);
      done       <= done_nxt;
`ifdef DIV_SCHED_SQ_EN
      clk_out    <= sq_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched -- self-checking bench for div_sched
//
// Expected clk_flag and done cycle numbers are pushed to queues when the
// stimulus is driven. A negedge monitor pops them and compares each against
// the cycle where the DUT actually pulsed. Level checks such as reset values,
// busy, cfg_ready and cfg_err are made directly in the stimulus thread.
// ---------------------------------------------------------------------------
module tb_div_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_ratio = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        stop = 1'b0;
  logic        clk_flag;
  logic        busy;
  logic        done;
`ifdef DIV_SCHED_SQ_EN
  logic        clk_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int flag_q[$];
  int done_q[$];

  div_sched #(.CNT_W(8), .BL_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .start     (start),
    .burst_len (burst_len),
    .stop      (stop),
    .clk_flag  (clk_flag),
    .busy      (busy),
    .done      (done)
`ifdef DIV_SCHED_SQ_EN
    ,
    .clk_out   (clk_out)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Number of rising edges seen so far.
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drives one cycle of stimulus from a negedge. It returns at the next
  // negedge. e_no is the rising edge that sampled the stimulus.
  task automatic applyStimulus(input logic s, input logic p, input logic v,
                               input logic [7:0] r, input logic [15:0] bl,
                               output int e_no);
    start     = s;
    stop      = p;
    cfg_valid = v;
    cfg_ratio = r;
    burst_len = bl;
    e_no      = cyc + 1;
    @(negedge sys_clk);
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic waitCyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (cyc < target) checkOutput("wait_timeout", cyc, target);
  endtask

  task automatic pushFlags(input int e0, input int n, input int count);
    for (int k = 1; k <= count; k++) flag_q.push_back(e0 + k * n - 1);
  endtask

  // Scoreboard monitor for the pulse outputs.
  always @(negedge sys_clk) begin
    if (clk_flag) begin
      if (flag_q.size() > 0) checkOutput("flag_cycle", cyc, flag_q.pop_front());
      else                   checkOutput("flag_extra", cyc, -1);
    end
    if (done) begin
      if (done_q.size() > 0) checkOutput("done_cycle", cyc, done_q.pop_front());
      else                   checkOutput("done_extra", cyc, -1);
    end
  end

  initial begin
    int e;
    int h;
`ifdef DIV_SCHED_SQ_EN
    int hi;
`endif

    // Reset values.
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_clk_flag", int'(clk_flag), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Continuous run at the reset ratio 6. Stop arrives at cnt=2 of period 4.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd0, e);
    pushFlags(e, 6, 4);
    done_q.push_back(e + 24);
    checkOutput("run_busy", int'(busy), 1);
    waitCyc(e + 20);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 16'd0, h);
    waitCyc(e + 23);
    checkOutput("stop_busy_last", int'(busy), 1);
    waitCyc(e + 26);
    checkOutput("stop_busy_idle", int'(busy), 0);

    // Ratio 4 loaded in IDLE, then a burst of 3.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd4, 16'd0, h);
    checkOutput("idle_cfg_ready", int'(cfg_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd3, e);
    pushFlags(e, 4, 3);
    done_q.push_back(e + 12);
    waitCyc(e + 11);
    checkOutput("burst_busy_last", int'(busy), 1);
    waitCyc(e + 14);
    checkOutput("burst_busy_idle", int'(busy), 0);

    // Continuous run at 6. A ratio of 3 arrives mid-period and applies at the wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd6, 16'd0, h);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd0, e);
    flag_q.push_back(e + 5);
    flag_q.push_back(e + 11);
    flag_q.push_back(e + 14);
    flag_q.push_back(e + 17);
    flag_q.push_back(e + 20);
    done_q.push_back(e + 21);
    waitCyc(e + 8);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 16'd0, h);
    checkOutput("shadow_ready_low", int'(cfg_ready), 0);
    waitCyc(e + 11);
    checkOutput("shadow_ready_wrap", int'(cfg_ready), 0);
    waitCyc(e + 12);
    checkOutput("shadow_ready_back", int'(cfg_ready), 1);
    waitCyc(e + 18);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 16'd0, h);
    waitCyc(e + 23);

    // An illegal ratio pulses cfg_err and leaves the period at 3.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 16'd0, h);
    checkOutput("err_pulse", int'(cfg_err), 1);
    @(negedge sys_clk);
    checkOutput("err_clear", int'(cfg_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'd0, h);
    checkOutput("err_zero_pulse", int'(cfg_err), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd0, e);
    pushFlags(e, 3, 2);
    waitCyc(e + 7);

    // Reset in mid-run aborts at once with no done.
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abort_clk_flag", int'(clk_flag), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_cfg_err", int'(cfg_err), 0);
    checkOutput("abort_cfg_ready", int'(cfg_ready), 1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    checkOutput("abort_idle_busy", int'(busy), 0);

    // Burst of 1 after reset, which must be back at ratio 6.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd1, e);
    pushFlags(e, 6, 1);
    done_q.push_back(e + 6);
`ifdef DIV_SCHED_SQ_EN
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      hi += int'(clk_out);
      @(negedge sys_clk);
    end
    checkOutput("sq_high_n6", hi, 3);
`endif
    waitCyc(e + 8);

    // Start and stop together give a full run. A start in RUN is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 16'd2, e);
    pushFlags(e, 6, 2);
    done_q.push_back(e + 12);
    waitCyc(e + 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd5, h);
    waitCyc(e + 20);
    checkOutput("final_busy", int'(busy), 0);

    checkOutput("flags_left", flag_q.size(), 0);
    checkOutput("dones_left", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
